data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Word-organised data memory that answers load/store requests from the single-cycle core's memory stage over a req/ack handshake.
- Responder end of the core's data-memory interface.
- Inserts a programmable number of wait states so the core's stall logic can be exercised.
- Flags misaligned and out-of-range accesses with an error response; such accesses never modify memory.

Parameters:
- ADDR_WIDTH, 10, word-address width; memory depth is 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, extra BUSY cycles before the access is performed; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  request valid; held high by the core until ack.
- wren  input  1  1 = store, 0 = load; sampled with req.
- addr  input  32  byte address; sampled with req.
- wdata  input  32  store data; sampled with req.
- byte_en  input  4  store byte lanes; bit i enables wdata[8i+7:8i]; ignored for loads.
- ack  output  1  one-cycle response strobe.
- rdata  output  32  load data, or merged word after a store; valid while ack=1.
- err  output  1  error response; valid while ack=1.

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - State returns to IDLE; ack=0, err=0, rdata=0, counter=0.
  - Memory array is not cleared.
- States: IDLE, BUSY, RESP.
- IDLE:
  - req=1 at an edge latches wren, addr, wdata and byte_en into internal registers.
  - Valid request: go to BUSY with cnt=WAIT_CYCLES.
  - Error request: go directly to RESP with err=1 and rdata=0.
  - A request is an error when addr[1:0]!=0 or addr[31:ADDR_WIDTH+2]!=0.
- BUSY:
  - cnt!=0: decrement cnt and stay in BUSY.
  - cnt==0: perform the access at this edge, then go to RESP.
  - Load: rdata = mem[addr[ADDR_WIDTH+1:2]].
  - Store: each lane with byte_en=1 takes the corresponding wdata byte; other lanes are unchanged. rdata = the merged word.
- RESP:
  - ack=1 for exactly one cycle.
  - Go to IDLE at the next edge, clearing ack and err.
  - rdata holds its value until the next access completes.
- Latency, with the request captured at edge k:
  - Valid request: ack is high in the cycle after edge k+WAIT_CYCLES+1.
  - Error request: ack is high in the cycle after edge k+1.
- Back-to-back requests:
  - req is only sampled in IDLE.
  - If req is still high in IDLE after a response, a new transaction starts with the then-current inputs.
  - Minimum period is WAIT_CYCLES+3 cycles.
- Input changes outside IDLE are ignored; latched values are used.
- wren=1 with byte_en=0000 is a legal store: no bytes change, and ack returns the unchanged word.
- Reset mid-operation:
  - Abandons the transaction with no ack.
  - A store aborted before its access edge leaves memory unchanged.
- No combinational path from any input to ack, rdata or err; all outputs are registered.

Test Plan (ADDR_WIDTH=10, WAIT_CYCLES=2):
1. Store then load:
   - Store 0xDEADBEEF to addr 0x10 with byte_en=1111, captured at edge k -> ack=1, err=0 in the cycle after edge k+3.
   - Load 0x10 -> rdata=0xDEADBEEF.
2. Partial store:
   - Store 0x0000AA00 to addr 0x10 with byte_en=0010 -> ack rdata=0xDEADAAEF.
   - Load 0x10 -> 0xDEADAAEF.
3. Misaligned access:
   - Store to addr 0x12 captured at edge k -> ack=1, err=1, rdata=0 in the cycle after edge k+1.
   - Load 0x10 -> still 0xDEADAAEF.
4. Out of range:
   - Load addr 0x00001000 -> err=1 with 1-cycle latency.
   - Load addr 0x00000FFC (last word) -> err=0 and normal latency.
5. Back-to-back:
   - Hold req=1 across two loads of 0x0 and 0x4 -> acks 5 cycles apart, each exactly one cycle wide.
   - With WAIT_CYCLES=0, acks are 3 cycles apart.
6. Reset during store:
   - Assert rst while in BUSY during a store of 0x12345678 to 0x20 -> ack=0, rdata=0 immediately.
   - Later load of 0x20 -> returns the prior contents.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering the core's load/store req/ack handshake.
// Adds WAIT_CYCLES busy cycles per access; misaligned/out-of-range requests get an error response.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wren,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    wren_q, wren_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              be_q, be_d;
  logic                    bad_q, bad_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;

  logic [31:0]             mem_q [2**ADDR_WIDTH];
  logic                    mem_we;
  logic [31:0]             merged;
  logic                    req_bad;

  assign req_bad = (addr[1:0] != 2'b00) || ((addr >> (ADDR_WIDTH + 2)) != '0);

  always_comb begin
    merged = mem_q[idx_q];
    for (int unsigned i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // An error request is classified at capture and answered after one pass
  // through BUSY, so it never waits out the programmed wait states.
  always_comb begin
    state_d = state_q;
    wren_d  = wren_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    bad_d   = bad_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          wren_d  = wren;
          idx_d   = addr[ADDR_WIDTH+1:2];
          wdata_d = wdata;
          be_d    = byte_en;
          bad_d   = req_bad;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bad_q) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we  = wren_q;
          rdata_d = wren_q ? merged : mem_q[idx_q];
          ack_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wren_q  <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wren_q  <= wren_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= merged;
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule
